// File: rtl/if_id_fetch_queue_pkg.sv
// Shared fetch-path constants for the IF/ID fetch queue.
// Both the datapath width and the bubble instruction are defined here.
package if_id_fetch_queue_pkg;

    localparam int WORD_WIDTH = 32;
    localparam logic [WORD_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/if_id_fetch_queue.sv
// IF/ID fetch queue: buffers {pc, instruction} words from IF and hands them to ID under
// valid/ready, freezing IF when full and discarding everything on a taken branch.
module if_id_fetch_queue
    import if_id_fetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WORD_WIDTH-1:0] in_pc,
    input  logic [WORD_WIDTH-1:0] in_instruction,
    output logic                  if_freeze,
    input  logic                  flush,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [WORD_WIDTH-1:0] id_pc,
    output logic [WORD_WIDTH-1:0] id_instruction,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [2*WORD_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic                    enq;
    logic                    deq;
    logic [2*WORD_WIDTH-1:0] head;

    // Freeze depends only on the registered count, so a full queue never
    // passes a word straight through even when ID drains it this cycle.
    assign if_freeze = (count == FULL_COUNT);
    assign id_valid  = (count != '0);
    assign enq       = in_valid & ~if_freeze & ~flush;
    assign deq       = id_valid & id_ready & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; the output mask hides stale entries.
    always_ff @(posedge clk) begin
        if (!rst && enq) mem[wr_ptr] <= {in_pc, in_instruction};
    end

    always_comb begin
        head           = mem[rd_ptr];
        id_pc          = '0;
        id_instruction = NOP_INSTR;
        if (id_valid) begin
            id_pc          = head[2*WORD_WIDTH-1:WORD_WIDTH];
            id_instruction = head[WORD_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (count <= FULL_COUNT);
    end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the fetch buffer.
module tb_if_id_fetch_queue;
    import if_id_fetch_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int PTR_W = $clog2(DEPTH);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic [WORD_WIDTH-1:0] in_pc = '0;
    logic [WORD_WIDTH-1:0] in_instruction = '0;
    logic                  if_freeze;
    logic                  flush = 1'b0;
    logic                  id_valid;
    logic                  id_ready = 1'b0;
    logic [WORD_WIDTH-1:0] id_pc;
    logic [WORD_WIDTH-1:0] id_instruction;
    logic [PTR_W:0]        count;

    logic [2*WORD_WIDTH-1:0] model_q[$];
    int num_checks = 0;
    int num_fails  = 0;

    if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc),
        .in_instruction(in_instruction), .if_freeze(if_freeze), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
        .id_instruction(id_instruction), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Outputs are compared 1 time unit after the edge, once the model has absorbed it.
    task automatic check_all();
        logic [WORD_WIDTH-1:0] exp_pc;
        logic [WORD_WIDTH-1:0] exp_instr;
        exp_pc    = '0;
        exp_instr = '0;
        if (model_q.size() > 0) begin
            exp_pc    = model_q[0][2*WORD_WIDTH-1:WORD_WIDTH];
            exp_instr = model_q[0][WORD_WIDTH-1:0];
        end
        check_output("count", 64'(count), 64'(model_q.size()));
        check_output("id_valid", 64'(id_valid), 64'(model_q.size() != 0));
        check_output("if_freeze", 64'(if_freeze), 64'(model_q.size() == DEPTH));
        check_output("id_pc", 64'(id_pc), 64'(exp_pc));
        check_output("id_instruction", 64'(id_instruction), 64'(exp_instr));
    endtask

    task automatic apply_stimulus(input logic r, input logic v, input logic [WORD_WIDTH-1:0] pc,
                                  input logic [WORD_WIDTH-1:0] instr, input logic f, input logic rdy);
        bit full_before;
        bit take_head;
        bit take_word;
        rst            = r;
        in_valid       = v;
        in_pc          = pc;
        in_instruction = instr;
        flush          = f;
        id_ready       = rdy;
        full_before    = (model_q.size() == DEPTH);
        take_head      = (model_q.size() > 0) && rdy;
        take_word      = v && !full_before;
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (take_head) void'(model_q.pop_front());
            if (take_word) model_q.push_back({pc, instr});
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [WORD_WIDTH-1:0] pc_ctr;

        // Reset for two cycles, then idle.
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0);

        // Fill to full with ID stalled; pc 5 must stay held outside the queue.
        for (int i = 1; i <= 4; i++)
            apply_stimulus(0, 1, WORD_WIDTH'(i), 32'hE000_0000 + WORD_WIDTH'(i), 0, 0);
        apply_stimulus(0, 1, 5, 32'hE000_0005, 0, 0);

        // Drain one while full; pc 5 enters on the following edge, then drain in order.
        apply_stimulus(0, 1, 5, 32'hE000_0005, 0, 1);
        apply_stimulus(0, 1, 5, 32'hE000_0005, 0, 0);
        for (int i = 0; i < 5; i++)
            apply_stimulus(0, 0, 0, 0, 0, 1);

        // Streaming: ten words, pointers wrap past the last entry.
        for (int i = 0; i < 10; i++)
            apply_stimulus(0, 1, WORD_WIDTH'(16 + i), 32'hA000_0000 + WORD_WIDTH'(i), 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);

        // Flush with three queued, ID ready and an incoming word: all discarded.
        for (int i = 0; i < 3; i++)
            apply_stimulus(0, 1, WORD_WIDTH'(40 + i), 32'hB000_0000 + WORD_WIDTH'(i), 0, 0);
        apply_stimulus(0, 1, 43, 32'hB000_0003, 1, 1);
        apply_stimulus(0, 1, 44, 32'hB000_0004, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);

        // Reset dominating flush mid-stream, then enqueue resumes.
        apply_stimulus(0, 1, 50, 32'hC000_0000, 0, 0);
        apply_stimulus(0, 1, 51, 32'hC000_0001, 0, 0);
        apply_stimulus(1, 1, 52, 32'hC000_0002, 1, 1);
        apply_stimulus(0, 1, 53, 32'hC000_0003, 0, 0);
        apply_stimulus(0, 1, 54, 32'hC000_0004, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1);

        // Random traffic; the pc advances only when the model says the word was taken.
        pc_ctr = 32'h100;
        for (int i = 0; i < 400; i++) begin
            logic r, v, f, rdy;
            logic [WORD_WIDTH-1:0] instr;
            bit accepted;
            r     = ($urandom_range(0, 99) < 2);
            f     = ($urandom_range(0, 99) < 5);
            v     = ($urandom_range(0, 99) < 75);
            rdy   = ($urandom_range(0, 99) < 55);
            instr = $urandom;
            accepted = v && !r && !f && (model_q.size() < DEPTH);
            apply_stimulus(r, v, pc_ctr, instr, f, rdy);
            if (accepted) pc_ctr = pc_ctr + 4;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
